ft245_tx_sched: RTL and testbench

- Read-side drain controller for the async `fifo`.
- Pops bytes from the FIFO read port whenever the FT245 USB chip can accept data.
- Drives the FT245 asynchronous write strobe sequence for each byte.
- Issues a send-immediate (SI/WU) pulse on flush request once the FIFO is empty.
- Sits in the `rclk` domain, between the `fifo` instance carrying CCD pixel/status bytes and the FT245 pins.

---
 rtl/ft245_tx_sched_pkg.sv | 39 +++
 rtl/ft245_tx_sched_if.sv | 26 ++
 rtl/ft245_tx_sched_sync_2ff.sv | 26 ++
 rtl/ft245_tx_sched.sv | 195 +++++++++++++++++++
 tb/tb_ft245_tx_sched.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ft245_tx_sched_pkg.sv
// ft245_pkg: shared definitions for the FT245 transmit scheduler and the
// receive path. Holds the 3-bit state encoding, the default strobe timing
// and the helper that sizes the state cycle counter.
package ft245_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_HOLD    = 3'd3,
    ST_RECOVER = 3'd4,
    ST_FLUSH   = 3'd5
  } ft245_state_e;

  localparam int unsigned FT245_DATA_WIDTH     = 8;
  localparam int unsigned FT245_SETUP_CYCLES   = 1;
  localparam int unsigned FT245_WR_CYCLES      = 2;
  localparam int unsigned FT245_HOLD_CYCLES    = 1;
  localparam int unsigned FT245_RECOVER_CYCLES = 3;
  localparam int unsigned FT245_SI_CYCLES      = 2;

  // Counter width: clog2 of the largest phase length, plus one bit of headroom.
  function automatic int unsigned ft245_cnt_width(
    input int unsigned a,
    input int unsigned b,
    input int unsigned c,
    input int unsigned d,
    input int unsigned e
  );
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/ft245_tx_sched_if.sv
// ft245_tx_sched_if: fifo read port plus FT245 pin bundle seen by the
// transmit scheduler. master = scheduler, slave = fifo/pin environment.
interface ft245_tx_sched_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rempty;
  logic                  rinc;
  logic                  txe_n;
  logic                  flush_req;
  logic [DATA_WIDTH-1:0] d;
  logic                  d_oe;
  logic                  wr;
  logic                  si_wu_n;
  logic                  busy;

  modport master (
    input  rdata, rempty, txe_n, flush_req,
    output rinc, d, d_oe, wr, si_wu_n, busy
  );

  modport slave (
    output rdata, rempty, txe_n, flush_req,
    input  rinc, d, d_oe, wr, si_wu_n, busy
  );
endinterface

// File: rtl/ft245_tx_sched_sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous level with a
// configurable reset value (TXE# idles high, so the scheduler uses 1).
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/ft245_tx_sched.sv
// ft245_tx_sched: drains the async fifo read side into the FT245 write port.
// Each byte: pop + drive data, hold SETUP, WR high, hold, recover. A latched
// flush request pulses SI/WU# once the fifo is empty.
// Optional: define FT245_TX_STATS_EN to add tx_count / flush_count outputs.
module ft245_tx_sched
  import ft245_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = FT245_DATA_WIDTH,
  parameter int unsigned SETUP_CYCLES   = FT245_SETUP_CYCLES,
  parameter int unsigned WR_CYCLES      = FT245_WR_CYCLES,
  parameter int unsigned HOLD_CYCLES    = FT245_HOLD_CYCLES,
  parameter int unsigned RECOVER_CYCLES = FT245_RECOVER_CYCLES,
  parameter int unsigned SI_CYCLES      = FT245_SI_CYCLES
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  ft245_tx_sched_if.master      bus
`ifdef FT245_TX_STATS_EN
  ,
  output logic [31:0]           tx_count,
  output logic [15:0]           flush_count
`endif
);

  localparam int unsigned CNT_W = ft245_cnt_width(SETUP_CYCLES, WR_CYCLES,
                                                  HOLD_CYCLES, RECOVER_CYCLES,
                                                  SI_CYCLES);
  // Counter counts down to zero, so each phase reloads with length-1.
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LD   = CNT_W'(RECOVER_CYCLES - 1);
  localparam logic [CNT_W-1:0] SI_LD    = CNT_W'(SI_CYCLES - 1);

  ft245_state_e          r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_flush;
  logic                  r_rinc;
  logic [DATA_WIDTH-1:0] r_d;
  logic                  r_d_oe;
  logic                  r_wr;
  logic                  r_si_wu_n;
  logic                  r_busy;

  logic w_txe_s;
  logic w_cnt_zero;
  logic w_pop;
  logic w_flush_go;
  logic w_flush_exit;

  sync_2ff #(.RST_VAL(1'b1)) u_txe_sync (
    .clk   (rclk),
    .rst_n (rrst_n),
    .i_d   (bus.txe_n),
    .o_q   (w_txe_s)
  );

  assign w_cnt_zero   = (r_cnt == {CNT_W{1'b0}});
  // Data wins over flush; flush only once the fifo has drained.
  assign w_pop        = (r_state == ST_IDLE) && !bus.rempty && !w_txe_s;
  assign w_flush_go   = (r_state == ST_IDLE) && !w_pop && r_flush &&
                        bus.rempty && !w_txe_s;
  assign w_flush_exit = (r_state == ST_FLUSH) && w_cnt_zero;

  // Sticky flush flag: a new request wins over the clear on FLUSH exit.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_flush <= 1'b0;
    end else begin
      r_flush <= bus.flush_req | (r_flush & ~w_flush_exit);
    end
  end

  // Byte/flush sequencer with registered pin outputs.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= {CNT_W{1'b0}};
      r_rinc    <= 1'b0;
      r_d       <= {DATA_WIDTH{1'b0}};
      r_d_oe    <= 1'b0;
      r_wr      <= 1'b0;
      r_si_wu_n <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_rinc <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_d     <= bus.rdata;
            r_d_oe  <= 1'b1;
            r_rinc  <= 1'b1;
            r_cnt   <= SETUP_LD;
            r_busy  <= 1'b1;
            r_state <= ST_SETUP;
          end else if (w_flush_go) begin
            r_si_wu_n <= 1'b0;
            r_cnt     <= SI_LD;
            r_busy    <= 1'b1;
            r_state   <= ST_FLUSH;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          if (w_cnt_zero) begin
            r_wr    <= 1'b1;
            r_cnt   <= WR_LD;
            r_state <= ST_STROBE;
          end else begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_STROBE: begin
          if (w_cnt_zero) begin
            r_wr    <= 1'b0;
            r_cnt   <= HOLD_LD;
            r_state <= ST_HOLD;
          end else begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_HOLD: begin
          if (w_cnt_zero) begin
            r_d_oe  <= 1'b0;
            r_cnt   <= REC_LD;
            r_state <= ST_RECOVER;
          end else begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_RECOVER: begin
          if (w_cnt_zero) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_FLUSH: begin
          if (w_cnt_zero) begin
            r_si_wu_n <= 1'b1;
            r_cnt     <= REC_LD;
            r_state   <= ST_RECOVER;
          end else begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          r_d_oe    <= 1'b0;
          r_wr      <= 1'b0;
          r_si_wu_n <= 1'b1;
          r_busy    <= 1'b0;
          r_cnt     <= {CNT_W{1'b0}};
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rinc    = r_rinc;
  assign bus.d       = r_d;
  assign bus.d_oe    = r_d_oe;
  assign bus.wr      = r_wr;
  assign bus.si_wu_n = r_si_wu_n;
  assign bus.busy    = r_busy;

`ifdef FT245_TX_STATS_EN
  logic [31:0] r_tx_count;
  logic [15:0] r_flush_count;

  // Free-running byte and flush counters, wrapping at their width.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_tx_count    <= 32'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (w_pop) begin
        r_tx_count <= r_tx_count + 32'd1;
      end else begin
        r_tx_count <= r_tx_count;
      end
      if (w_flush_go) begin
        r_flush_count <= r_flush_count + 16'd1;
      end else begin
        r_flush_count <= r_flush_count;
      end
    end
  end

  assign tx_count    = r_tx_count;
  assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_ft245_tx_sched.sv
// tb_ft245_tx_sched: directed + randomized bench. A queue stands in for the
// fifo; a byte scoreboard (push order) and pulse-width/period rules drawn
// from the FT245 timing form the reference.
`timescale 1ns/1ps
module tb_ft245_tx_sched;

  localparam int unsigned DW     = 8;
  localparam int unsigned SETUP  = 1;
  localparam int unsigned WRC    = 2;
  localparam int unsigned HOLD   = 1;
  localparam int unsigned REC    = 3;
  localparam int unsigned SIC    = 2;
  localparam int unsigned PERIOD = 1 + SETUP + WRC + HOLD + REC;

  logic clk = 1'b0;
  logic rrst_n = 1'b0;
  always #5 clk = ~clk;

  ft245_tx_sched_if #(.DATA_WIDTH(DW)) bif ();

`ifdef FT245_TX_STATS_EN
  logic [31:0] tx_count;
  logic [15:0] flush_count;
`endif

  ft245_tx_sched #(
    .DATA_WIDTH(DW), .SETUP_CYCLES(SETUP), .WR_CYCLES(WRC),
    .HOLD_CYCLES(HOLD), .RECOVER_CYCLES(REC), .SI_CYCLES(SIC)
  ) dut (
    .rclk   (clk),
    .rrst_n (rrst_n),
    .bus    (bif)
`ifdef FT245_TX_STATS_EN
    ,
    .tx_count    (tx_count),
    .flush_count (flush_count)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  logic [7:0] fifo_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] exp_q[$];
  int rinc_cycs[$];
  int cyc = 0;
  int n_rinc = 0, n_wr = 0, n_si = 0, inflight = 0;
  int wr_w = 0, si_w = 0, last_wr_fall = 0, last_si_fall = 0;
  logic prev_wr = 1'b0, prev_si = 1'b1, prev_rinc = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor + fifo model, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rrst_n) begin
      for (int k = 0; k < inflight; k++)
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      inflight = 0; prev_wr = 1'b0; prev_si = 1'b1; prev_rinc = 1'b0;
      wr_w = 0; si_w = 0;
    end else begin
      if (bif.rinc) begin
        n_rinc++; inflight++; rinc_cycs.push_back(cyc);
        check_val("rinc_single_cycle", {31'd0, prev_rinc}, 32'd0);
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      end
      if (bif.wr) wr_w++;
      if (bif.wr && !prev_wr) begin
        n_wr++;
        if (inflight > 0) inflight--;
        check_val("wr_with_d_oe", {31'd0, bif.d_oe}, 32'd1);
        if (exp_q.size() > 0) check_val("byte_order", {24'd0, bif.d}, {24'd0, exp_q.pop_front()});
        else check_val("wr_unexpected", 32'd1, 32'd0);
      end
      if (!bif.wr && prev_wr) begin
        check_val("wr_width", wr_w, WRC);
        wr_w = 0; last_wr_fall = cyc;
      end
      if (!bif.si_wu_n) si_w++;
      if (!bif.si_wu_n && prev_si) begin
        n_si++; last_si_fall = cyc;
        check_val("si_fifo_empty", fifo_q.size(), 32'd0);
      end
      if (bif.si_wu_n && !prev_si) begin
        check_val("si_width", si_w, SIC);
        si_w = 0;
      end
      prev_wr = bif.wr; prev_si = bif.si_wu_n; prev_rinc = bif.rinc;
    end
    while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    bif.rdata  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    bif.rempty = (fifo_q.size() == 0);
  end

  task automatic push(input logic [7:0] b);
    pend_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1 bif.flush_req = 1'b1;
    @(posedge clk); #1 bif.flush_req = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int k;
    k = 0;
    do begin
      @(negedge clk); #1; k++;
    end while (k < bound && !(pend_q.size() == 0 && fifo_q.size() == 0 &&
                              exp_q.size() == 0 && bif.busy == 1'b0 &&
                              bif.si_wu_n == 1'b1));
    check_val(tag, {31'd0, (k < bound)}, 32'd1);
  endtask

  int base_rinc, base_wr, base_si, t0, k;
  logic found;
`ifdef FT245_TX_STATS_EN
  logic [31:0] base_tx;
  logic [15:0] base_fl;
`endif

  initial begin
    bif.txe_n = 1'b1;
    bif.flush_req = 1'b0;
    rrst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_val("rst_rinc", {31'd0, bif.rinc}, 32'd0);
    check_val("rst_d", {24'd0, bif.d}, 32'd0);
    check_val("rst_d_oe", {31'd0, bif.d_oe}, 32'd0);
    check_val("rst_wr", {31'd0, bif.wr}, 32'd0);
    check_val("rst_si", {31'd0, bif.si_wu_n}, 32'd1);
    check_val("rst_busy", {31'd0, bif.busy}, 32'd0);
`ifdef FT245_TX_STATS_EN
    check_val("rst_tx_count", tx_count, 32'd0);
    check_val("rst_flush_count", {16'd0, flush_count}, 32'd0);
`endif
    @(negedge clk) rrst_n = 1'b1;

    // Four bytes back to back with TXE# low.
    bif.txe_n = 1'b0;
    repeat (4) @(negedge clk); #1;
    rinc_cycs.delete(); base_rinc = n_rinc; base_wr = n_wr;
    push(8'h01); push(8'h02); push(8'h0A); push(8'h0B);
    wait_drain("drain_four", 300);
    check_val("four_rinc", n_rinc - base_rinc, 32'd4);
    check_val("four_wr", n_wr - base_wr, 32'd4);
    check_val("four_rempty", {31'd0, bif.rempty}, 32'd1);
    for (int i = 1; i < rinc_cycs.size(); i++)
      check_val("byte_period", rinc_cycs[i] - rinc_cycs[i-1], PERIOD);

    // TXE# high blocks pops; dropping it gives rinc three cycles later.
    @(posedge clk); #1 bif.txe_n = 1'b1;
    repeat (4) @(negedge clk); #1;
    base_rinc = n_rinc; rinc_cycs.delete();
    for (int i = 0; i < 3; i++) push(8'($urandom_range(0, 255)));
    repeat (20) @(negedge clk); #1;
    check_val("txe_high_no_pop", n_rinc - base_rinc, 32'd0);
    @(posedge clk); #1 t0 = cyc; bif.txe_n = 1'b0;
    k = 0;
    while (k < 20 && rinc_cycs.size() == 0) begin @(negedge clk); #1; k++; end
    check_val("txe_wake_seen", {31'd0, (rinc_cycs.size() > 0)}, 32'd1);
    if (rinc_cycs.size() > 0) check_val("txe_wake_latency", rinc_cycs[0] - t0, 32'd3);
    wait_drain("drain_txe", 300);

    // Flush with two bytes queued: bytes first, then one SI pulse.
    base_wr = n_wr; base_si = n_si;
    push(8'($urandom_range(0, 255))); push(8'($urandom_range(0, 255)));
    pulse_flush();
    k = 0;
    while (k < 200 && n_si == base_si) begin @(negedge clk); #1; k++; end
    check_val("flush_seen", {31'd0, (n_si != base_si)}, 32'd1);
    wait_drain("drain_flush", 200);
    check_val("flush_bytes", n_wr - base_wr, 32'd2);
    check_val("flush_pulses", n_si - base_si, 32'd1);
    check_val("flush_after_bytes", {31'd0, (last_si_fall > last_wr_fall)}, 32'd1);
    check_val("flush_busy_low", {31'd0, bif.busy}, 32'd0);

    // TXE# raised during the strobe of 0x0A: byte completes, next waits.
    push(8'h0A); push(8'h0B);
    found = 1'b0; k = 0;
    while (k < 100 && !found) begin
      @(negedge clk); #1; k++;
      found = bif.wr && (bif.d == 8'h0A);
    end
    check_val("strobe_0a_seen", {31'd0, found}, 32'd1);
    bif.txe_n = 1'b1;
    base_wr = n_wr;
    k = 0;
    while (k < 20 && bif.d_oe) begin @(negedge clk); #1; k++; end
    check_val("strobe_0a_done", {31'd0, bif.d_oe}, 32'd0);
    base_rinc = n_rinc;
    repeat (30) @(negedge clk); #1;
    check_val("txe_mid_no_pop", n_rinc - base_rinc, 32'd0);
    check_val("txe_mid_left", fifo_q.size(), 32'd1);
    bif.txe_n = 1'b0;
    wait_drain("drain_mid", 300);
    check_val("txe_mid_resume", n_wr - base_wr, 32'd1);

    // Asynchronous reset in the middle of a strobe.
    push(8'($urandom_range(0, 255)));
    found = 1'b0; k = 0;
    while (k < 100 && !found) begin @(negedge clk); #1; k++; found = bif.wr; end
    check_val("rst_mid_strobe_seen", {31'd0, found}, 32'd1);
    rrst_n = 1'b0; #1;
    check_val("rst_mid_wr", {31'd0, bif.wr}, 32'd0);
    check_val("rst_mid_d_oe", {31'd0, bif.d_oe}, 32'd0);
    check_val("rst_mid_si", {31'd0, bif.si_wu_n}, 32'd1);
    check_val("rst_mid_busy", {31'd0, bif.busy}, 32'd0);
    check_val("rst_mid_rinc", {31'd0, bif.rinc}, 32'd0);
    check_val("rst_mid_d", {24'd0, bif.d}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rrst_n = 1'b1;
    wait_drain("drain_after_rst", 100);

    // Randomized traffic, TXE# toggling and flush requests.
    for (int it = 0; it < 60; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4) begin
        int n;
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) push(8'($urandom_range(0, 255)));
      end else if (r == 5) begin
        bif.txe_n = ~bif.txe_n;
      end else if (r == 6) begin
        pulse_flush();
      end
      repeat ($urandom_range(1, 12)) @(negedge clk);
      #1;
    end
    bif.txe_n = 1'b0;
    wait_drain("drain_random", 2000);
    repeat (30) @(negedge clk);
    wait_drain("drain_random_flush", 200);

`ifdef FT245_TX_STATS_EN
    base_tx = tx_count; base_fl = flush_count;
    for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)));
    pulse_flush();
    base_si = n_si; k = 0;
    while (k < 300 && n_si == base_si) begin @(negedge clk); #1; k++; end
    wait_drain("drain_stats", 200);
    check_val("stats_tx", tx_count - base_tx, 32'd5);
    check_val("stats_flush", {16'd0, 16'(flush_count - base_fl)}, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
